// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg -- shared definitions for the program counter / fetch
// sequencer of the 9-bit core.
//   pc_state_t : fetch sequencer states
//   PC_W_DEF   : default program counter width (ROM depth 2^PC_W_DEF)
//   kSEL_NONE  : PCRegSelect code meaning "no saved register"
//   sat_inc16  : saturating 16-bit increment used by the perf counters
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

    localparam int         PC_W_DEF  = 10;
    localparam logic [1:0] kSEL_NONE = 2'b00;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if -- decoder/harness side bundle of the fetch unit.
//   master : harness + control decoder (drives strobes, reads ProgCtr/Done)
//   slave  : pc_fetch_unit
// Signals: Start, Ack, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect[1:0],
//          SaveEn, OffsetIn[7:0], ZeroIn, FlagWrEn (to fetch unit);
//          ProgCtr[PC_W-1:0], Done, CycleCnt[15:0], TakenCnt[15:0] (from it).
interface pc_fetch_unit_if
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic            Start;
    logic            Ack;
    logic            JumpEqual;
    logic            JumpNotEqual;
    logic            OffsetEn;
    logic [1:0]      PCRegSelect;
    logic            SaveEn;
    logic [7:0]      OffsetIn;
    logic            ZeroIn;
    logic            FlagWrEn;
    logic [PC_W-1:0] ProgCtr;
    logic            Done;
    logic [15:0]     CycleCnt;
    logic [15:0]     TakenCnt;

    modport master (
        output Start, Ack, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect,
               SaveEn, OffsetIn, ZeroIn, FlagWrEn,
        input  ProgCtr, Done, CycleCnt, TakenCnt
    );

    modport slave (
        input  Start, Ack, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect,
               SaveEn, OffsetIn, ZeroIn, FlagWrEn,
        output ProgCtr, Done, CycleCnt, TakenCnt
    );
endinterface

// File: rtl/pc_save_regs.sv
// pc_save_regs -- three PC_W-bit saved-address registers (branch targets).
//   clk_i, rst_i : clock, synchronous active-high reset (clears all to 0)
//   en_i         : write enable
//   sel_i        : register select, 01/10/11 -> reg 1/2/3, 00 -> none
//   data_i       : write data
//   rd_data_o    : combinational read of the selected register (00 reads 0)
module pc_save_regs
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [1:0]      sel_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] rd_data_o
);
    logic [3:1][PC_W-1:0] regs_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else if (en_i && sel_i != kSEL_NONE) begin
            regs_q[sel_i] <= data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (sel_i)
            2'b01:   rd_data_o = regs_q[1];
            2'b10:   rd_data_o = regs_q[2];
            2'b11:   rd_data_o = regs_q[3];
            default: rd_data_o = '0;
        endcase
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- program counter and fetch sequencer for the 9-bit core.
// Drives the instruction ROM address, executes je/jne/spc strobes from the
// decoder against three saved-address registers, and runs the Start/Done
// handshake with the test harness (IDLE -> ARMED -> RUN -> HALT).
//   Clk   : clock, all state on the rising edge
//   Reset : synchronous, active-high, highest priority
//   bus   : pc_fetch_unit_if.slave (strobes in; ProgCtr/Done/counters out)
// Build option: define PC_PERF_CNT_EN to implement CycleCnt/TakenCnt;
// without it both outputs are tied to 0 and no counter registers exist.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_fetch_unit_if.slave bus
);
    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, save_data, target;
    logic            eq_q, eq_d;
    logic            done_q, done_d;
    logic            in_run, sel_valid, jump_hit, exec, taken, save_wr;

    assign in_run    = (state_q == RUN);
    assign sel_valid = (bus.PCRegSelect != kSEL_NONE);
    // Both je and jne high always hits, since one of the terms must be true.
    assign jump_hit  = (bus.JumpEqual & eq_q) | (bus.JumpNotEqual & ~eq_q);
    // An instruction only takes effect when the run is neither aborted nor halting.
    assign exec      = in_run & ~bus.Start & ~bus.Ack;
    assign taken     = exec & jump_hit & sel_valid;
    assign save_wr   = exec & bus.SaveEn & sel_valid & ~taken;

    // Natural wrap modulo 2^PC_W for both the increment and the saved value.
    assign pc_inc    = pc_q + PC_W'(1);
    assign save_data = pc_inc + (bus.OffsetEn ? PC_W'(bus.OffsetIn) : '0);

    pc_save_regs #(.PC_W(PC_W)) u_save_regs (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .en_i      (save_wr),
        .sel_i     (bus.PCRegSelect),
        .data_i    (save_data),
        .rd_data_o (target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (bus.Start) state_d = ARMED;
            end
            ARMED: begin
                pc_d = '0;
                if (!bus.Start) state_d = RUN;
            end
            RUN: begin
                if (bus.Start) begin
                    state_d = ARMED;
                    pc_d    = '0;
                end else if (bus.Ack) begin
                    state_d = HALT;
                end else if (taken) begin
                    pc_d = target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALT: begin
                if (bus.Start) begin
                    state_d = ARMED;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // Jump decision above used eq_q; the new flag is visible next cycle.
    assign eq_d   = (in_run && bus.FlagWrEn) ? bus.ZeroIn : eq_q;
    assign done_d = (state_d == HALT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            eq_q    <= eq_d;
            done_q  <= done_d;
        end
    end

    assign bus.ProgCtr = pc_q;
    assign bus.Done    = done_q;

`ifdef PC_PERF_CNT_EN
    logic [15:0] cyc_q, cyc_d, tkn_q, tkn_d;
    logic        arm_entry;

    assign arm_entry = (state_d == ARMED) && (state_q != ARMED);

    always_comb begin
        cyc_d = cyc_q;
        tkn_d = tkn_q;
        if (arm_entry) begin
            cyc_d = '0;
            tkn_d = '0;
        end else begin
            if (in_run) cyc_d = sat_inc16(cyc_q);
            if (taken)  tkn_d = sat_inc16(tkn_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cyc_q <= '0;
            tkn_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            tkn_q <= tkn_d;
        end
    end

    assign bus.CycleCnt = cyc_q;
    assign bus.TakenCnt = tkn_q;
`else
    assign bus.CycleCnt = '0;
    assign bus.TakenCnt = '0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program counter and fetch sequencer for the 9-bit core. Sits directly upstream of the instruction ROM and the control decoder: it drives the instruction address, and it consumes the decoder's jump, save and select strobes plus the ALU zero flag. It owns three saved-address registers used as branch targets, and it runs the Start/Done program handshake with the test harness.

## Interface
- PC_W, 10: program counter width; the instruction ROM depth is 2^PC_W.
- Clk  in  1  single clock. Every register updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  harness request to run or restart the program.
- Ack  in  1  decoder halt indication (the instruction is all ones).
- JumpEqual  in  1  je strobe.
- JumpNotEqual  in  1  jne strobe.
- OffsetEn  in  1  add OffsetIn to the saved address.
- PCRegSelect  in  2  00 none; 01/10/11 select saved register 1/2/3.
- SaveEn  in  1  spc strobe; top_level decodes it from the opcode.
- OffsetIn  in  8  unsigned offset; top_level drives it from r8.
- ZeroIn  in  1  ALU zero flag for the current instruction.
- FlagWrEn  in  1  capture ZeroIn into the flag register; driven high on ALU-sourced register writes.
- ProgCtr  out  PC_W  instruction ROM address.
- Done  out  1  program halted.
- CycleCnt  out  16  RUN cycle count.
- TakenCnt  out  16  taken-jump count.

## Operation
- States: IDLE, ARMED, RUN, HALT.
  - IDLE: Start=1 goes to ARMED.
  - ARMED: Start=0 goes to RUN.
  - RUN: Ack=1 goes to HALT.
  - HALT: Start=1 goes to ARMED.
- ProgCtr is held at 0 in IDLE and ARMED, and is forced to 0 on entry to ARMED.
- Start=1 during RUN aborts to ARMED with ProgCtr=0.
- Saved registers and the flag survive a restart. Only Reset clears them.
- Flag: when FlagWrEn=1 in RUN, Eq <= ZeroIn. Otherwise Eq holds.
- In RUN, each cycle applies the first matching rule:
  1. Ack=1: ProgCtr holds and the state goes to HALT. Any jump or save in the same cycle is ignored.
  2. JumpEqual & Eq, or JumpNotEqual & !Eq, with PCRegSelect≠00: ProgCtr <= SavedReg[PCRegSelect]. The jump is counted as taken.
  3. Otherwise ProgCtr <= ProgCtr+1. A jump with PCRegSelect=00 is a no-op.
- Save: SaveEn=1 with PCRegSelect≠00 and no taken jump writes SavedReg[sel].
  - Written value is ProgCtr + 1, plus zero-extended OffsetIn when OffsetEn=1.
  - The sum is taken modulo 2^PC_W.
  - SaveEn with sel=00 is ignored.
- If JumpEqual and JumpNotEqual are both high, the jump is always taken.
- If a taken jump and SaveEn coincide, the jump wins and the save is suppressed.
- ProgCtr = 2^PC_W−1 increments to 0.
- The flag update and the jump decision in the same cycle use the old Eq.

## Timing
- Reset values:
  - ProgCtr=0, Done=0, Eq=0.
  - SavedReg1..3=0.
  - CycleCnt=0, TakenCnt=0.
  - State=IDLE.
- Reset takes priority over every other input.
- Instruction ROM is combinational, so each instruction executes in one cycle.
- Jump latency: the target appears on ProgCtr in the cycle after the je/jne instruction.
- A saved register is readable as a jump target in the cycle after the save.
- Done is registered: it is 1 starting the first cycle in HALT, and 0 starting the first cycle in ARMED.
- Counters:
  - Both saturate at 0xFFFF.
  - Both clear on entry to ARMED.
  - CycleCnt increments on every RUN cycle, including the Ack cycle.

## Configuration
- PC_PERF_CNT_EN:
  - Defined: CycleCnt and TakenCnt operate as specified above.
  - Undefined: neither counter register exists, and both outputs are tied to 0.
- All other behaviour is identical with or without the macro.

## Structure
- The definitions package gains:
  - Enum typedef pc_state_t {IDLE, ARMED, RUN, HALT}.
  - Constant PC_W_DEF = 10.
  - Localparam kSEL_NONE = 2'b00.
- One sub-module, pc_save_regs:
  - Three PC_W-bit registers with a synchronous write port (sel, data, en).
  - A combinational read indexed by sel.
  - Index 00 reads 0.

## Test plan
- Reset, then Start 1→0: ProgCtr=0,1,2,3 on successive cycles and Done=0.
- At ProgCtr=5: SaveEn=1, sel=01, OffsetEn=0. At ProgCtr=9: FlagWrEn=1, ZeroIn=1. Then JumpEqual=1, sel=01: next ProgCtr=6 and TakenCnt=1.
- SaveEn=1, sel=10, OffsetEn=1, OffsetIn=0x20 at ProgCtr=3, then JumpNotEqual with Eq=0 and sel=10: ProgCtr=0x24.
- ProgCtr=1023 with no jump: next ProgCtr=0. Save with OffsetIn=0xFF at ProgCtr=1000: saved value=232.
- Ack=1 at ProgCtr=12 together with a taken jump: ProgCtr holds 12, Done=1 next cycle. Start=1: ProgCtr=0, Done=0, counters=0.
- Start=1 mid-RUN at ProgCtr=7: ARMED with ProgCtr=0, and saved registers keep their values. Reset mid-RUN: all outputs return to their reset values on the next edge.
